// File: rtl/sram_ctrl_pkg.sv
// Shared types and defaults for the single-port SRAM RW arbiter.
// Build option: define INIT_CLEAR_EN to zero the macro after every reset.
package sram_ctrl_pkg;

  localparam int SRAM_DATA_WIDTH = 2;
  localparam int SRAM_ADDR_WIDTH = 4;
  // Handshake edge to rvalid edge; set by the macro's registered read path.
  localparam int READ_LAT        = 2;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_t;

  // One stage of the read-return shift register.
  typedef struct packed {
    logic    vld;
    req_id_t id;
  } rd_slot_t;

endpackage

// File: rtl/sram_rr_arb2.sv
// Two-way round-robin arbiter. The grant is combinational; the pointer moves
// to the other requester after every accepted request.
module sram_rr_arb2
  import sram_ctrl_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic [1:0] i_valid,
  output logic [1:0] o_grant
);

  req_id_t r_ptr;

  // Grant: a lone requester always wins, a tie goes to the pointer.
  always_comb begin
    o_grant = 2'b00;
    if (i_en) begin
      if (i_valid == 2'b11) begin
        o_grant = (r_ptr == REQ0) ? 2'b01 : 2'b10;
      end else begin
        o_grant = i_valid;
      end
    end else begin
      o_grant = 2'b00;
    end
  end

  // Pointer: after an accept, favour the requester that was not served.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= REQ0;
    end else if (o_grant != 2'b00) begin
      r_ptr <= o_grant[0] ? REQ1 : REQ0;
    end else begin
      r_ptr <= r_ptr;
    end
  end

endmodule

// File: rtl/sram_rw_arbiter.sv
// Shares the RW port of one OpenRAM single-port macro between two requesters.
// Macro pins are driven from registers; dout0 is captured READ_LAT edges
// after the accepting edge. Build option INIT_CLEAR_EN adds a post-reset
// sweep that writes zero to every address before requests are accepted.
module sram_rw_arbiter
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
  parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_rvalid,
  output logic [DATA_WIDTH-1:0] req0_rdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_rvalid,
  output logic [DATA_WIDTH-1:0] req1_rdata,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0,
  output logic                  init_done
);

`ifdef INIT_CLEAR_EN
  localparam logic [ADDR_WIDTH:0] L_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam state_t L_RST_STATE = INIT;
`else
  localparam state_t L_RST_STATE = RUN;
`endif

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_init_done;
  logic                  w_clr_issue;
  logic [ADDR_WIDTH-1:0] w_clr_addr;
  logic                  w_run;
  logic [1:0]            w_grant;
  logic                  w_xfer;
  req_id_t               w_id;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic                  r_csb;
  logic                  r_web;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_din;
  rd_slot_t              r_pipe [READ_LAT];
  logic                  r_rvalid0;
  logic                  r_rvalid1;
  logic [DATA_WIDTH-1:0] r_rdata0;
  logic [DATA_WIDTH-1:0] r_rdata1;

`ifdef INIT_CLEAR_EN
  logic [ADDR_WIDTH:0]   r_clr_cnt;

  // Sweep counter: one address per cycle while INIT, restarts on reset.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      r_clr_cnt <= {(ADDR_WIDTH+1){1'b0}};
    end else if (w_clr_issue) begin
      r_clr_cnt <= r_clr_cnt + {{ADDR_WIDTH{1'b0}}, 1'b1};
    end else begin
      r_clr_cnt <= r_clr_cnt;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      r_state <= L_RST_STATE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: INIT leaves on the edge after the last sweep address issues.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
`ifdef INIT_CLEAR_EN
      INIT: begin
        if (r_clr_cnt == L_DEPTH) begin
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = INIT;
        end
      end
`else
      INIT:    w_state_nxt = RUN;
`endif
      RUN:     w_state_nxt = RUN;
      default: w_state_nxt = L_RST_STATE;
    endcase
  end

  // State outputs: sweep write strobe and address.
  always_comb begin
`ifdef INIT_CLEAR_EN
    w_clr_issue = (r_state == INIT) && (r_clr_cnt != L_DEPTH);
    w_clr_addr  = r_clr_cnt[ADDR_WIDTH-1:0];
`else
    w_clr_issue = 1'b0;
    w_clr_addr  = {ADDR_WIDTH{1'b0}};
`endif
  end

  // init_done rises together with entry into RUN.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      r_init_done <= 1'b0;
    end else begin
      r_init_done <= (w_state_nxt == RUN);
    end
  end

  assign w_run = (r_state == RUN) && r_init_done && !rst0;

  sram_rr_arb2 u_arb (
    .i_clk   (clk0),
    .i_rst   (rst0),
    .i_en    (w_run),
    .i_valid ({req1_valid, req0_valid}),
    .o_grant (w_grant)
  );

  assign req0_ready = w_grant[0];
  assign req1_ready = w_grant[1];
  assign w_xfer     = w_grant[0] | w_grant[1];
  assign w_id       = w_grant[1] ? REQ1 : REQ0;
  assign w_we       = w_grant[1] ? req1_we    : req0_we;
  assign w_addr     = w_grant[1] ? req1_addr  : req0_addr;
  assign w_wdata    = w_grant[1] ? req1_wdata : req0_wdata;

  // Macro pin registers: sweep write, granted op, or deselect holding addr/din.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      r_csb  <= 1'b1;
      r_web  <= 1'b1;
      r_addr <= {ADDR_WIDTH{1'b0}};
      r_din  <= {DATA_WIDTH{1'b0}};
    end else if (w_clr_issue) begin
      r_csb  <= 1'b0;
      r_web  <= 1'b0;
      r_addr <= w_clr_addr;
      r_din  <= {DATA_WIDTH{1'b0}};
    end else if (w_xfer) begin
      r_csb  <= 1'b0;
      r_web  <= !w_we;
      r_addr <= w_addr;
      r_din  <= w_wdata;
    end else begin
      r_csb  <= 1'b1;
      r_web  <= 1'b1;
    end
  end

  // Read-return shift register tagging each accepted read with its requester.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      for (int i = 0; i < READ_LAT; i++) begin
        r_pipe[i] <= '{vld: 1'b0, id: REQ0};
      end
    end else begin
      r_pipe[0] <= '{vld: w_xfer && !w_we, id: w_id};
      for (int i = 1; i < READ_LAT; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  // Capture macro dout into the owning requester's rdata with a one-cycle rvalid.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= {DATA_WIDTH{1'b0}};
      r_rdata1  <= {DATA_WIDTH{1'b0}};
    end else begin
      r_rvalid0 <= r_pipe[READ_LAT-1].vld && (r_pipe[READ_LAT-1].id == REQ0);
      r_rvalid1 <= r_pipe[READ_LAT-1].vld && (r_pipe[READ_LAT-1].id == REQ1);
      if (r_pipe[READ_LAT-1].vld && (r_pipe[READ_LAT-1].id == REQ0)) begin
        r_rdata0 <= sram_dout0;
      end
      if (r_pipe[READ_LAT-1].vld && (r_pipe[READ_LAT-1].id == REQ1)) begin
        r_rdata1 <= sram_dout0;
      end
    end
  end

  assign sram_csb0   = r_csb;
  assign sram_web0   = r_web;
  assign sram_addr0  = r_addr;
  assign sram_din0   = r_din;
  assign req0_rvalid = r_rvalid0;
  assign req1_rvalid = r_rvalid1;
  assign req0_rdata  = r_rdata0;
  assign req1_rdata  = r_rdata1;
  assign init_done   = r_init_done;

endmodule

// File: tb/tb_sram_rw_arbiter.sv
// Bench for sram_rw_arbiter: behavioural macro model plus a transaction-level
// reference (memory array, response queue with due cycles, last-served rule).
// Build option INIT_CLEAR_EN selects the post-reset sweep expectations.
module tb_sram_rw_arbiter;

  localparam int DW    = 2;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
`ifdef INIT_CLEAR_EN
  localparam int INIT_EDGES = DEPTH + 1;
  localparam bit CLR        = 1'b1;
`else
  localparam int INIT_EDGES = 1;
  localparam bit CLR        = 1'b0;
`endif

  logic          clk0 = 1'b0;
  logic          rst0 = 1'b1;
  logic          tv    [2];
  logic          twe   [2];
  logic [AW-1:0] taddr [2];
  logic [DW-1:0] tdat  [2];

  logic          req0_ready, req1_ready, req0_rvalid, req1_rvalid;
  logic [DW-1:0] req0_rdata, req1_rdata;
  logic          sram_csb0, sram_web0, init_done;
  logic [AW-1:0] sram_addr0;
  logic [DW-1:0] sram_din0;
  logic [DW-1:0] sram_dout0;

  sram_rw_arbiter dut (
    .clk0(clk0), .rst0(rst0),
    .req0_valid(tv[0]), .req0_ready(req0_ready), .req0_we(twe[0]),
    .req0_addr(taddr[0]), .req0_wdata(tdat[0]),
    .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
    .req1_valid(tv[1]), .req1_ready(req1_ready), .req1_we(twe[1]),
    .req1_addr(taddr[1]), .req1_wdata(tdat[1]),
    .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_addr0(sram_addr0),
    .sram_din0(sram_din0), .sram_dout0(sram_dout0), .init_done(init_done)
  );

  always #5 clk0 = ~clk0;

  // Macro model: samples pins at posedge, reads shortly after, writes at negedge.
  logic [DW-1:0] mem [DEPTH];
  logic          m_csb = 1'b1, m_web = 1'b1;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din;

  always @(posedge clk0) begin
    m_csb  = sram_csb0;
    m_web  = sram_web0;
    m_addr = sram_addr0;
    m_din  = sram_din0;
    #1;
    if (!m_csb && m_web) sram_dout0 = mem[m_addr];
  end

  always @(negedge clk0) begin
    if (!m_csb && !m_web) mem[m_addr] = m_din;
  end

  // Reference model state.
  typedef struct {
    int            due;
    int            id;
    logic [DW-1:0] data;
  } resp_t;

  logic [DW-1:0] exp_mem [DEPTH];
  resp_t         rq [$];
  int            cyc;
  int            init_left;
  bit            last1;
  logic          e_csb, e_web;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_din;
  logic [DW-1:0] e_rdata [2];
  bit            g_q [2];
  int            n_assert = 0;
  int            n_fail   = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic model_reset();
    rq.delete();
    last1      = 1'b1;
    init_left  = INIT_EDGES;
    e_csb      = 1'b1;
    e_web      = 1'b1;
    e_addr     = '0;
    e_din      = '0;
    e_rdata[0] = '0;
    e_rdata[1] = '0;
    if (CLR) begin
      for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
    end
  endtask

  // One clock: check everything at negedge, then advance the model to the next edge.
  task automatic step();
    bit    en;
    bit    g  [2];
    bit    rv [2];
    int    pre;
    int    id;
    resp_t keep [$];
    @(negedge clk0);
    en    = (init_left == 0) && !rst0;
    g[0]  = 1'b0;
    g[1]  = 1'b0;
    if (en) begin
      if (tv[0] && tv[1]) begin
        if (last1) g[0] = 1'b1; else g[1] = 1'b1;
      end else begin
        g[0] = tv[0];
        g[1] = tv[1];
      end
    end
    chk("req0_ready", req0_ready, g[0]);
    chk("req1_ready", req1_ready, g[1]);
    chk("init_done", init_done, (init_left == 0));
    chk("sram_csb0", sram_csb0, e_csb);
    chk("sram_web0", sram_web0, e_web);
    chk("sram_addr0", sram_addr0, e_addr);
    chk("sram_din0", sram_din0, e_din);
    rv[0] = 1'b0;
    rv[1] = 1'b0;
    foreach (rq[k]) begin
      if (rq[k].due == cyc) begin
        rv[rq[k].id]      = 1'b1;
        e_rdata[rq[k].id] = rq[k].data;
      end else if (rq[k].due > cyc) begin
        keep.push_back(rq[k]);
      end
    end
    rq = keep;
    chk("req0_rvalid", req0_rvalid, rv[0]);
    chk("req1_rvalid", req1_rvalid, rv[1]);
    chk("req0_rdata", req0_rdata, e_rdata[0]);
    chk("req1_rdata", req1_rdata, e_rdata[1]);
    g_q[0] = g[0];
    g_q[1] = g[1];
    if (rst0) begin
      model_reset();
    end else begin
      pre = init_left;
      if (init_left > 0) init_left--;
      if (pre >= 2) begin
        e_csb  = 1'b0;
        e_web  = 1'b0;
        e_addr = AW'(INIT_EDGES - pre);
        e_din  = '0;
      end else if (g[0] || g[1]) begin
        id     = g[1] ? 1 : 0;
        e_csb  = 1'b0;
        e_web  = !twe[id];
        e_addr = taddr[id];
        e_din  = tdat[id];
        if (twe[id]) exp_mem[taddr[id]] = tdat[id];
        else rq.push_back('{cyc + 3, id, exp_mem[taddr[id]]});
        last1 = (id == 1);
      end else begin
        e_csb = 1'b1;
        e_web = 1'b1;
      end
    end
    @(posedge clk0);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    tv[0] = 1'b0;
    tv[1] = 1'b0;
    repeat (n) step();
  endtask

  task automatic do_reset(input int n);
    tv[0] = 1'b0;
    tv[1] = 1'b0;
    rst0  = 1'b1;
    repeat (n) step();
    rst0  = 1'b0;
    repeat (INIT_EDGES) step();
  endtask

  // Present one request and keep it up until accepted (bounded).
  task automatic issue(input int id, input bit we, input int addr, input int data);
    bit ok = 1'b0;
    tv[id]    = 1'b1;
    twe[id]   = we;
    taddr[id] = AW'(addr);
    tdat[id]  = DW'(data);
    for (int k = 0; k < 20; k++) begin
      step();
      if (g_q[id]) begin
        ok = 1'b1;
        break;
      end
    end
    tv[id] = 1'b0;
    chk("accept_in_time", ok, 1'b1);
  endtask

  initial begin
    bit alt;
    for (int i = 0; i < 2; i++) begin
      tv[i] = 1'b0; twe[i] = 1'b0; taddr[i] = '0; tdat[i] = '0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = DW'($urandom);
      exp_mem[i] = mem[i];
    end
    cyc = 0;
    model_reset();
    @(posedge clk0);
    cyc++;
    #1;

    // Reset state, then release and wait out INIT.
    do_reset(3);
    chk("t1_init_done", init_done, 1'b1);

    // Write then read-after-write on requester 0.
    issue(0, 1'b1, 5, 2);
    issue(0, 1'b0, 5, 0);
    idle(4);
    chk("t2_rdata", req0_rdata, 2'b10);

    // Preload, then both requesters reading continuously: grants alternate.
    issue(0, 1'b1, 1, 1);
    issue(1, 1'b1, 2, 3);
    tv[0] = 1'b1; twe[0] = 1'b0; taddr[0] = 4'd1;
    tv[1] = 1'b1; twe[1] = 1'b0; taddr[1] = 4'd2;
    for (int k = 0; k < 8; k++) begin
      step();
      alt = ((k % 2) == 0);
      chk("t3_alternate", g_q[0], alt);
    end
    idle(4);

    // Requester 1 alone is accepted every cycle.
    tv[1] = 1'b1; twe[1] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      taddr[1] = AW'($urandom);
      step();
      chk("t4_accept", g_q[1], 1'b1);
    end
    idle(4);

    // Reset one cycle after a read accept drops the read and deselects.
    issue(0, 1'b0, 3, 0);
    rst0 = 1'b1;
    step();
    rst0 = 1'b0;
    chk("t5_csb_after_rst", sram_csb0, 1'b1);
    idle(INIT_EDGES + 3);

`ifdef INIT_CLEAR_EN
    // Sweep clears a memory preloaded with all ones.
    for (int i = 0; i < DEPTH; i++) mem[i] = 2'b11;
    do_reset(2);
    issue(0, 1'b0, 0, 0);
    issue(1, 1'b0, 15, 0);
    idle(4);
    chk("t6_rdata_addr0", req0_rdata, 2'b00);
    chk("t6_rdata_addr15", req1_rdata, 2'b00);
`endif

    // Random traffic with occasional resets.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!tv[i] && ($urandom_range(0, 3) != 0)) begin
          tv[i]    = 1'b1;
          twe[i]   = 1'($urandom_range(0, 1));
          taddr[i] = AW'($urandom);
          tdat[i]  = DW'($urandom);
        end
      end
      rst0 = ($urandom_range(0, 149) == 0);
      step();
      for (int i = 0; i < 2; i++) begin
        if (g_q[i]) tv[i] = 1'b0;
      end
    end
    rst0 = 1'b0;
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_rw_arbiter.md
Name: sram_rw_arbiter

Overview:
- Shares the single RW port of one OpenRAM single-port macro (clk0/csb0/web0/addr0/din0/dout0 interface) between two requesters.
- Round-robin arbitration, valid/ready request handshake, fixed-latency read return with per-requester rvalid.
- Drives macro control pins from registers and captures macro dout0 into a register.
- Sits between the macro instance and client logic; one instance per macro.

Parameters:
- DATA_WIDTH, 2, macro word width
- ADDR_WIDTH, 4, macro address width; depth = 1<<ADDR_WIDTH
- READ_LAT, 2, handshake edge to rvalid edge (fixed by macro timing; not tunable)

Ports:
- clk0 in 1: single clock, shared with macro clk0
- rst0 in 1: synchronous, active-high reset
- req0_valid in 1: requester 0 request valid
- req0_ready out 1: requester 0 accepted this cycle
- req0_we in 1: 1=write, 0=read
- req0_addr in ADDR_WIDTH: word address
- req0_wdata in DATA_WIDTH: write data
- req0_rvalid out 1: one-cycle pulse, read data valid
- req0_rdata out DATA_WIDTH: read data
- req1_*: identical set for requester 1
- sram_csb0 out 1: macro chip select, active low
- sram_web0 out 1: macro write enable, active low
- sram_addr0 out ADDR_WIDTH: macro address
- sram_din0 out DATA_WIDTH: macro write data
- sram_dout0 in DATA_WIDTH: macro read data
- init_done out 1: high once block accepts requests

Behaviour:
- Reset values (rst0 sampled high at posedge):
  - sram_csb0=1, sram_web0=1, sram_addr0=0, sram_din0=0
  - both ready/rvalid=0, both rdata=0
  - rr pointer=requester 0
  - read pipeline flushed
  - init_done=0 until the state machine enters RUN
- States: INIT -> RUN. INIT exists only with INIT_CLEAR_EN; otherwise reset goes straight to RUN and init_done=1 on the first cycle after reset.
- Arbitration (RUN only; combinational grant):
  - One valid requester: it wins.
  - Both valid: the requester named by the rr pointer wins.
  - After each accepted request the pointer moves to the other requester.
  - reqN_ready = grant to N; never asserted in INIT or during reset.
- Request rules: requester holds valid and fields stable until ready. Transfer happens on an edge where valid&&ready.
- Issue: on a transfer edge the block registers:
  - sram_csb0=0
  - sram_web0=!we
  - sram_addr0=addr
  - sram_din0=wdata
- Idle cycles register sram_csb0=1 and sram_web0=1; sram_addr0 and sram_din0 hold their last values.
- Macro samples the issued values at the next edge. Throughput is one op per cycle, back-to-back, no bubbles.
- Read return:
  - 2-stage shift register of {valid, requester id}.
  - On the edge READ_LAT after the transfer edge: sram_dout0 is captured into reqN_rdata and reqN_rvalid=1 for one cycle.
  - rdata holds until the next read return for that requester.
  - No response back-pressure.
- Writes produce no response.
- Ordering: a read issued the cycle after a write to the same address returns the new data (macro writes at negedge of the sampling cycle).
- Reset mid-operation: in-flight reads are dropped with no rvalid, and the macro is deselected on the next edge.

Optional Feature:
- Macro: INIT_CLEAR_EN
- Defined:
  - After reset the block is in INIT and writes 0 to every address 0..depth-1, one per cycle.
  - Both readies stay 0 throughout INIT.
  - The transition to RUN occurs on the edge after the last address is issued; init_done rises with it.
  - The sweep takes depth cycles (16 by default).
  - rst0 during INIT restarts the sweep at address 0.
- Undefined: no INIT state, no sweep counter; memory contents after reset are undefined (X in model).

Decomposition:
- Package sram_ctrl_pkg:
  - default DATA_WIDTH/ADDR_WIDTH
  - READ_LAT=2
  - state enum {INIT, RUN}
  - requester id type (1 bit)
- One natural sub-module, sram_rr_arb2: 2-way round-robin grant with pointer update on accept.

Test Plan:
1. After reset: no requests -> sram_csb0=1, sram_web0=1, both ready=0 during reset; init_done=1 one cycle after (17 cycles after, with INIT_CLEAR_EN).
2. Req0 write addr 5 data 2'b10, then req0 read addr 5 next cycle -> req0_rvalid pulse 2 edges after read accept, req0_rdata=2'b10; req1_rvalid stays 0.
3. Both valid continuously, reads of addr 1 (req0) and 2 (req1) preloaded 2'b01/2'b11 -> grants alternate 0,1,0,1; rvalid pulses alternate each cycle with correct data.
4. Req1 alone valid for 4 cycles -> accepted every cycle, with no stall waiting for pointer.
5. rst0 asserted one cycle after a read accept -> no rvalid ever for that read; sram_csb0=1 on next edge.
6. INIT_CLEAR_EN build, memory preloaded 2'b11 everywhere -> after init_done, reads of addr 0 and 15 return 2'b00.
